lmul: RTL

Pipelined shift-and-add multiply-accumulate that computes `quotient * denominator + remainder` and reports whether the triple is a well-formed division result. It is the inverse of the team's pipelined long divider: divider outputs feed straight into it to rebuild the numerator. It sits beside the divider in datapaths and benches as a round-trip checker and general-purpose fixed-latency multiplier. It is fully pipelined, accepts one operand set per clock, and has no stall.

---
 rtl/lmul_if.sv | 31 +++
 rtl/lmul.sv | 91 +++++++++
 2 files changed

// File: rtl/lmul_if.sv
// Operand/result bundle for the lmul multiply-accumulate pipeline.
// Handshake: valid_in qualifies the operands sampled on a rising clock edge.
// There is no ready signal, so every beat is accepted. valid_out qualifies
// the result signals on the cycle where they appear. Data moves every cycle
// whether or not valid is high.
interface lmul_if #(
  parameter int NUMERATOR_WIDTH   = 10,
  parameter int DENOMINATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH    = 10
);
  logic [QUOTIENT_WIDTH-1:0]    quotient_in;
  logic [DENOMINATOR_WIDTH-1:0] denominator_in;
  logic [NUMERATOR_WIDTH-1:0]   remainder_in;
  logic                         valid_in;
  logic [NUMERATOR_WIDTH-1:0]   numerator_out;
  logic                         overflow_out;
  logic                         invalid_out;
  logic                         valid_out;

  // Operand source, which is usually the divider or a bench.
  modport master (
    output quotient_in, denominator_in, remainder_in, valid_in,
    input  numerator_out, overflow_out, invalid_out, valid_out
  );

  // The lmul pipeline itself.
  modport slave (
    input  quotient_in, denominator_in, remainder_in, valid_in,
    output numerator_out, overflow_out, invalid_out, valid_out
  );
endinterface

// File: rtl/lmul.sv
// lmul: fixed-latency shift-and-add multiply-accumulate, q*d + r.
// It rebuilds a numerator from a divider's quotient, remainder and denominator,
// and it flags triples that are not well formed (r >= d) and results that
// do not fit in NUMERATOR_WIDTH bits.
// The pipeline has QUOTIENT_WIDTH+2 stages with no stall. Stage 0 captures the
// operands. Stages 1..QUOTIENT_WIDTH each perform one MSB-first Horner step.
// The last stage adds r and registers the outputs. There is no FSM. Each
// beat's state travels with the beat down the pipeline.
module lmul #(
  parameter int NUMERATOR_WIDTH   = 10,
  parameter int DENOMINATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH    = 10
) (
  input  logic   clk,
  input  logic   resetb,
  lmul_if.slave  bus
);
  localparam int QW    = QUOTIENT_WIDTH;
  localparam int DW    = DENOMINATOR_WIDTH;
  localparam int NW    = NUMERATOR_WIDTH;
  // One bit of headroom above the full product leaves room for +r without wrap.
  localparam int ACC_W = QW + DW + 1;

  // Per-stage registers. Index i holds the value at the output of stage i.
  // q is not needed after stage QW-1, because its last bit is consumed there.
  logic [QW-1:0]    r_q   [0:QW-1];
  logic [DW-1:0]    r_d   [0:QW];
  logic [NW-1:0]    r_r   [0:QW];
  logic [ACC_W-1:0] r_acc [0:QW];
  logic             r_vld [0:QW];

  logic [NW-1:0]    r_num;
  logic             r_ovf;
  logic             r_inv;
  logic             r_vout;

  logic [ACC_W-1:0] w_sum;

  // The final addend joins the completed product at full width.
  assign w_sum = r_acc[QW] + ACC_W'(r_r[QW]);

  // Shift structure: capture the operands, run the Horner steps, then register the results.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < QW; i++) begin
        r_q[i] <= '0;
      end
      for (int i = 0; i <= QW; i++) begin
        r_d[i]   <= '0;
        r_r[i]   <= '0;
        r_acc[i] <= '0;
        r_vld[i] <= 1'b0;
      end
      r_num  <= '0;
      r_ovf  <= 1'b0;
      r_inv  <= 1'b0;
      r_vout <= 1'b0;
    end else begin
      // Stage 0 captures the operands unconditionally. The accumulator starts empty.
      r_q[0]   <= bus.quotient_in;
      r_d[0]   <= bus.denominator_in;
      r_r[0]   <= bus.remainder_in;
      r_acc[0] <= '0;
      r_vld[0] <= bus.valid_in;

      // Stage i doubles the running sum and adds d when quotient bit QW-i is set.
      for (int i = 1; i <= QW; i++) begin
        r_acc[i] <= (r_acc[i-1] << 1) + (r_q[i-1][QW-i] ? ACC_W'(r_d[i-1]) : '0);
        r_d[i]   <= r_d[i-1];
        r_r[i]   <= r_r[i-1];
        r_vld[i] <= r_vld[i-1];
      end
      for (int i = 1; i < QW; i++) begin
        r_q[i] <= r_q[i-1];
      end

      // The final stage adds r, truncates the result and evaluates both flags.
      // The flags are not gated by valid.
      r_num  <= w_sum[NW-1:0];
      r_ovf  <= |w_sum[ACC_W-1:NW];
      r_inv  <= (ACC_W'(r_r[QW]) >= ACC_W'(r_d[QW]));
      r_vout <= r_vld[QW];
    end
  end

  assign bus.numerator_out = r_num;
  assign bus.overflow_out  = r_ovf;
  assign bus.invalid_out   = r_inv;
  assign bus.valid_out     = r_vout;

endmodule
